uart_tx_arbiter: RTL and testbench

- Round-robin scheduler that shares the single UART transmitter among NUM_REQ byte producers.
- Accepts one byte per grant and drives the transmitter's writestart and 8-bit data inputs.
- Holds the transmitter until its writedone pulse, then enforces a configurable idle gap before the next frame.
- Sits between on-chip producers and the TX half of the UART top level.

---
 rtl/uart_tx_arbiter_if.sv | 56 +++++
 rtl/uart_tx_arbiter.sv | 237 +++++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter_if
// Bundle of every signal between the UART TX arbiter, its byte producers and
// the UART transmitter.
//
// Signals:
//   req           producer -> arbiter   per-requester request level
//   req_data      producer -> arbiter   byte per requester, requester i at [8i+7:8i]
//   gnt           arbiter  -> producer  one-hot one-cycle "byte accepted" pulse
//   done          arbiter  -> producer  one-hot one-cycle "frame finished" pulse
//   tx_writestart arbiter  -> UART TX   one-cycle start pulse
//   tx_data       arbiter  -> UART TX   byte being sent
//   tx_writedone  UART TX  -> arbiter   one-cycle frame-complete pulse
//   busy          arbiter  -> system    arbiter not idle
//   owner         arbiter  -> system    current / last granted requester
//   timeout_err   arbiter  -> system    sticky timeout flag (UART_ARB_TIMEOUT_EN only)
//
// Modports: master = the arbiter's view, slave = the surrounding system's view.
// Optional feature macro: UART_ARB_TIMEOUT_EN
// -----------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   gnt;
    logic [NUM_REQ-1:0]   done;
    logic                 tx_writestart;
    logic [7:0]           tx_data;
    logic                 tx_writedone;
    logic                 busy;
    logic [2:0]           owner;
`ifdef UART_ARB_TIMEOUT_EN
    logic                 timeout_err;

    modport master (
        input  req, req_data, tx_writedone,
        output gnt, done, tx_writestart, tx_data, busy, owner, timeout_err
    );

    modport slave (
        output req, req_data, tx_writedone,
        input  gnt, done, tx_writestart, tx_data, busy, owner, timeout_err
    );
`else
    modport master (
        input  req, req_data, tx_writedone,
        output gnt, done, tx_writestart, tx_data, busy, owner
    );

    modport slave (
        output req, req_data, tx_writedone,
        input  gnt, done, tx_writestart, tx_data, busy, owner
    );
`endif
endinterface

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte
// producers. One byte is accepted per grant, handed to the transmitter with a
// one-cycle writestart pulse, held until writedone, and followed by an idle
// gap of GAP_CYCLES clocks before the next grant.
//
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high reset
//   bus    uart_tx_arbiter_if.master (req/req_data/gnt/done/tx_*/busy/owner
//          and, with the optional feature, timeout_err)
//
// Parameters:
//   NUM_REQ        number of requesters (2..8)
//   GAP_CYCLES     idle clocks between writedone and the next grant (0..15)
//   TIMEOUT_CYCLES clocks to wait for writedone before aborting
//                  (only used with the optional feature)
//
// Optional feature macro: UART_ARB_TIMEOUT_EN
//   Defined   : WAIT_DONE aborts after TIMEOUT_CYCLES clocks, raising the
//               sticky timeout_err flag and pulsing done[owner].
//   Undefined : WAIT_DONE waits indefinitely; no timeout logic or port.
//
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    uart_tx_arbiter_if.master        bus
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_DONE,
        GAP
    } state_t;

    // Gap counter is loaded with GAP_CYCLES-1 so that GAP lasts exactly
    // GAP_CYCLES clocks; guarded so GAP_CYCLES=0 does not underflow.
    localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    state_t               state_reg, state_next;
    logic [NUM_REQ-1:0]   gnt_reg, gnt_next;
    logic [NUM_REQ-1:0]   done_reg, done_next;
    logic                 tx_writestart_reg, tx_writestart_next;
    logic [7:0]           tx_data_reg, tx_data_next;
    logic                 busy_reg, busy_next;
    logic [2:0]           owner_reg, owner_next;
    logic [2:0]           last_grant_reg, last_grant_next;
    logic [3:0]           gap_cnt_reg, gap_cnt_next;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0]      to_cnt_reg, to_cnt_next;
    logic                 timeout_err_reg, timeout_err_next;
`endif

    // -------------------------------------------------------------------------
    // Requests and bytes padded to 8 slots so a 3-bit index always fits.
    // -------------------------------------------------------------------------
    logic [7:0] req_pad;
    logic [7:0] byte_arr [8];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_slot
            if (gi < NUM_REQ) begin : g_used
                assign req_pad[gi]  = bus.req[gi];
                assign byte_arr[gi] = bus.req_data[8*gi +: 8];
            end else begin : g_pad
                assign req_pad[gi]  = 1'b0;
                assign byte_arr[gi] = 8'd0;
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Round-robin search: candidate gi is the requester gi positions after the
    // last grant (modulo NUM_REQ). The lowest offset with a request wins.
    // -------------------------------------------------------------------------
    logic [2:0]         cand_idx [1:NUM_REQ];
    logic [NUM_REQ:1]   cand_hit;
    logic [2:0]         winner;

    generate
        for (gi = 1; gi <= NUM_REQ; gi++) begin : g_cand
            logic [3:0] sum;
            assign sum          = {1'b0, last_grant_reg} + 4'(gi);
            assign cand_idx[gi] = (sum >= 4'(NUM_REQ)) ? 3'(sum - 4'(NUM_REQ)) : sum[2:0];
            assign cand_hit[gi] = req_pad[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        winner = '0;
        // Walk from the farthest candidate down so the nearest one wins.
        for (int i = NUM_REQ; i >= 1; i--) begin
            if (cand_hit[i]) begin
                winner = cand_idx[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg         <= IDLE;
            gnt_reg           <= '0;
            done_reg          <= '0;
            tx_writestart_reg <= 1'b0;
            tx_data_reg       <= 8'd0;
            busy_reg          <= 1'b0;
            owner_reg         <= 3'd0;
            last_grant_reg    <= 3'(NUM_REQ - 1);
            gap_cnt_reg       <= 4'd0;
`ifdef UART_ARB_TIMEOUT_EN
            to_cnt_reg        <= '0;
            timeout_err_reg   <= 1'b0;
`endif
        end else begin
            state_reg         <= state_next;
            gnt_reg           <= gnt_next;
            done_reg          <= done_next;
            tx_writestart_reg <= tx_writestart_next;
            tx_data_reg       <= tx_data_next;
            busy_reg          <= busy_next;
            owner_reg         <= owner_next;
            last_grant_reg    <= last_grant_next;
            gap_cnt_reg       <= gap_cnt_next;
`ifdef UART_ARB_TIMEOUT_EN
            to_cnt_reg        <= to_cnt_next;
            timeout_err_reg   <= timeout_err_next;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    logic frame_end;

    always_comb begin
        state_next         = state_reg;
        gnt_next           = '0;
        done_next          = '0;
        tx_writestart_next = 1'b0;
        tx_data_next       = tx_data_reg;
        owner_next         = owner_reg;
        last_grant_next    = last_grant_reg;
        gap_cnt_next       = gap_cnt_reg;
        frame_end          = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        to_cnt_next        = to_cnt_reg;
        timeout_err_next   = timeout_err_reg;
`endif

        case (state_reg)
            IDLE: begin
                if (|cand_hit) begin
                    state_next      = START;
                    gnt_next        = NUM_REQ'(8'd1 << winner);
                    tx_data_next    = byte_arr[winner];
                    owner_next      = winner;
                    last_grant_next = winner;
                end
            end

            START: begin
                tx_writestart_next = 1'b1;
                state_next         = WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
                to_cnt_next        = '0;
`endif
            end

            WAIT_DONE: begin
                // A writedone coinciding with our own writestart pulse cannot
                // belong to this frame.
                if (bus.tx_writedone && !tx_writestart_reg) begin
                    frame_end = 1'b1;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (to_cnt_reg == TO_LAST) begin
                    frame_end        = 1'b1;
                    timeout_err_next = 1'b1;
                end else begin
                    to_cnt_next = to_cnt_reg + 1'b1;
                end
`endif
                if (frame_end) begin
                    done_next = NUM_REQ'(8'd1 << owner_reg);
                    if (GAP_CYCLES > 0) begin
                        state_next   = GAP;
                        gap_cnt_next = GAP_LOAD;
                    end else begin
                        state_next   = IDLE;
                    end
                end
            end

            GAP: begin
                if (gap_cnt_reg == 4'd0) begin
                    state_next = IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg - 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    assign bus.gnt           = gnt_reg;
    assign bus.done          = done_reg;
    assign bus.tx_writestart = tx_writestart_reg;
    assign bus.tx_data       = tx_data_reg;
    assign bus.busy          = busy_reg;
    assign bus.owner         = owner_reg;
`ifdef UART_ARB_TIMEOUT_EN
    assign bus.timeout_err   = timeout_err_reg;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Self-checking bench for uart_tx_arbiter. Expected frames (owner, byte) are
// queued when requests are raised and compared when tx_writestart appears.
// Timing, done, reset and idle behaviour are checked inline.
// Optional feature macro: UART_ARB_TIMEOUT_EN (adds the timeout scenario).
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int GAP_CYCLES = 2;
`ifdef UART_ARB_TIMEOUT_EN
    localparam int TIMEOUT_CYCLES = 16;
`else
    localparam int TIMEOUT_CYCLES = 64;
`endif

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .GAP_CYCLES     (GAP_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0] owner;
        logic [7:0] data;
    } frame_t;

    frame_t exp_q[$];
    int n_compared   = 0;
    int n_mismatched = 0;
    int n_frames     = 0;
    logic [NUM_REQ-1:0] last_gnt = '0;

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic push_frame(input int o, input logic [7:0] d);
        frame_t f;
        f.owner = 3'(o);
        f.data  = d;
        exp_q.push_back(f);
    endtask

    task automatic wait_start();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            if (bus.tx_writestart) seen = 1'b1;
        end
        check_value("writestart_seen", 32'(seen), 32'd1);
    endtask

    // Pulse writedone for one cycle and check the done pulse that follows.
    task automatic finish_frame(input int o);
        bus.tx_writedone = 1'b1;
        @(negedge clk);
        bus.tx_writedone = 1'b0;
        check_value("done_onehot", 32'(bus.done), 32'(1 << o));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_gnt"},   32'(bus.gnt), 32'd0);
        check_value({tag, "_done"},  32'(bus.done), 32'd0);
        check_value({tag, "_ws"},    32'(bus.tx_writestart), 32'd0);
        check_value({tag, "_data"},  32'(bus.tx_data), 32'd0);
        check_value({tag, "_busy"},  32'(bus.busy), 32'd0);
        check_value({tag, "_owner"}, 32'(bus.owner), 32'd0);
`ifdef UART_ARB_TIMEOUT_EN
        check_value({tag, "_terr"},  32'(bus.timeout_err), 32'd0);
`endif
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Scoreboard: every transmitter start is matched against the next
    // expected frame.
    always @(negedge clk) begin
        frame_t e;
        if (reset) begin
            last_gnt = '0;
        end else begin
            if (bus.gnt != '0) last_gnt = bus.gnt;
            if (bus.tx_writestart) begin
                n_frames++;
                $display("frame %0d: owner=%0d data=%02h", n_frames, bus.owner, bus.tx_data);
                if (exp_q.size() == 0) begin
                    check_value("unexpected_frame", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_value("frame_owner", 32'(bus.owner), 32'(e.owner));
                    check_value("frame_data",  32'(bus.tx_data), 32'(e.data));
                    check_value("frame_gnt",   32'(last_gnt), 32'(1 << e.owner));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        bit seen_gnt, seen_done, seen_busy, early;

        bus.req          = '0;
        bus.req_data     = '0;
        bus.tx_writedone = 1'b0;
        reset            = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;

        // ---- Single request ------------------------------------------------
        bus.req              = 4'b0100;
        bus.req_data[23:16]  = 8'hA5;
        push_frame(2, 8'hA5);
        @(negedge clk);
        check_value("t1_gnt", 32'(bus.gnt), 32'b0100);
        bus.req = '0;
        @(negedge clk);
        check_value("t1_writestart", 32'(bus.tx_writestart), 32'd1);
        check_value("t1_gnt_clear", 32'(bus.gnt), 32'd0);
        repeat (10) @(negedge clk);
        finish_frame(2);
        check_value("t1_busy_gap0", 32'(bus.busy), 32'd1);
        @(negedge clk);
        check_value("t1_busy_gap1", 32'(bus.busy), 32'd1);
        check_value("t1_done_clear", 32'(bus.done), 32'd0);
        @(negedge clk);
        check_value("t1_busy_idle", 32'(bus.busy), 32'd0);
        check_value("t1_data_hold", 32'(bus.tx_data), 32'hA5);

        // ---- All request, rotation from reset ------------------------------
        do_reset();
        bus.req_data = {8'h43, 8'h32, 8'h21, 8'h10};
        bus.req      = 4'b1111;
        push_frame(0, 8'h10);
        push_frame(1, 8'h21);
        push_frame(2, 8'h32);
        push_frame(3, 8'h43);
        push_frame(0, 8'h10);
        for (int f = 0; f < 5; f++) begin
            wait_start();
            if (f == 4) bus.req = '0;
            repeat (2) @(negedge clk);
            finish_frame(f % 4);
            if (f < 4) begin
                // writedone edge to next gnt must be GAP_CYCLES+1 clocks
                cyc = 0;
                while (bus.gnt == '0 && cyc < 32) begin
                    @(negedge clk);
                    cyc++;
                end
                check_value("t2_spacing", 32'(cyc), 32'(GAP_CYCLES + 1));
            end
        end
        repeat (3) @(negedge clk);

        // ---- Pointer continuity --------------------------------------------
        bus.req_data[23:16] = 8'h5C;
        bus.req             = 4'b0100;
        push_frame(2, 8'h5C);
        wait_start();
        bus.req = '0;
        repeat (2) @(negedge clk);
        finish_frame(2);
        bus.req_data[7:0]   = 8'h3E;
        bus.req_data[23:16] = 8'h7D;
        bus.req             = 4'b0101;
        push_frame(0, 8'h3E);
        push_frame(2, 8'h7D);
        wait_start();
        bus.req = 4'b0100;
        repeat (2) @(negedge clk);
        finish_frame(0);
        wait_start();
        bus.req = '0;
        repeat (2) @(negedge clk);
        finish_frame(2);
        repeat (3) @(negedge clk);

        // ---- Withdrawal and spurious done ----------------------------------
        bus.req_data[31:24] = 8'hC3;
        bus.req             = 4'b1000;
        push_frame(3, 8'hC3);
        wait_start();
        bus.req = '0;
        @(negedge clk);
        bus.req = 4'b0010;
        repeat (2) @(negedge clk);
        bus.req = '0;
        @(negedge clk);
        finish_frame(3);
        repeat (3) @(negedge clk);
        bus.tx_writedone = 1'b1;
        @(negedge clk);
        bus.tx_writedone = 1'b0;
        seen_gnt = 0; seen_done = 0; seen_busy = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.gnt != '0)  seen_gnt  = 1'b1;
            if (bus.done != '0) seen_done = 1'b1;
            if (bus.busy)       seen_busy = 1'b1;
            @(negedge clk);
        end
        check_value("t4_no_gnt",  32'(seen_gnt),  32'd0);
        check_value("t4_no_done", 32'(seen_done), 32'd0);
        check_value("t4_idle",    32'(seen_busy), 32'd0);

        // ---- Reset mid-frame -----------------------------------------------
        bus.req_data[23:16] = 8'h99;
        bus.req             = 4'b0100;
        push_frame(2, 8'h99);
        wait_start();
        bus.req = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("t5_reset");
        reset = 1'b0;
        bus.tx_writedone = 1'b1;
        @(negedge clk);
        bus.tx_writedone = 1'b0;
        check_value("t5_no_done0", 32'(bus.done), 32'd0);
        check_value("t5_idle", 32'(bus.busy), 32'd0);
        @(negedge clk);
        check_value("t5_no_done1", 32'(bus.done), 32'd0);
        bus.req_data[7:0]   = 8'h11;
        bus.req_data[31:24] = 8'h44;
        bus.req             = 4'b1001;
        push_frame(0, 8'h11);
        wait_start();
        bus.req = '0;
        repeat (2) @(negedge clk);
        finish_frame(0);
        repeat (3) @(negedge clk);

`ifdef UART_ARB_TIMEOUT_EN
        // ---- Timeout -------------------------------------------------------
        bus.req_data[7:0] = 8'h6B;
        bus.req           = 4'b0001;
        push_frame(0, 8'h6B);
        wait_start();
        bus.req = '0;
        early = 1'b0;
        for (int i = 0; i < TIMEOUT_CYCLES - 1; i++) begin
            @(negedge clk);
            if (bus.done != '0 || bus.timeout_err) early = 1'b1;
        end
        check_value("t6_no_early", 32'(early), 32'd0);
        @(negedge clk);
        check_value("t6_done", 32'(bus.done), 32'b0001);
        check_value("t6_terr", 32'(bus.timeout_err), 32'd1);
        repeat (6) @(negedge clk);
        check_value("t6_terr_sticky", 32'(bus.timeout_err), 32'd1);
        check_value("t6_idle", 32'(bus.busy), 32'd0);
        do_reset();
        check_value("t6_terr_clear", 32'(bus.timeout_err), 32'd0);
`endif

        repeat (2) @(negedge clk);
        check_value("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
